// File: rtl/random_pos_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | random_pos_pkg : shared types and helpers for the random position arbiter |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package random_pos_pkg;

  localparam int c_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Full 32-bit result; the caller truncates to its state width (mod 2^BITS).
  function automatic logic [31:0] lcg_next(input logic [31:0] x,
                                           input logic [31:0] mult,
                                           input logic [31:0] add);
    return mult * x + add;
  endfunction

  // First set request at or above ptr, wrapping at n.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < c_MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if ((i < n) && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/random_pos_arbiter_lcg_core.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | lcg_core : linear-congruential generator state register (mod 2^BITS)      |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module lcg_core
  import random_pos_pkg::*;
#(
  parameter int BITS = 11,
  parameter int SEED = 3,
  parameter int MULT = 5,
  parameter int ADD  = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            step_en,
  input  logic            load_en,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] x
);

  logic [BITS-1:0] r_x;
  logic [BITS-1:0] w_x_next;

  assign w_x_next = BITS'(lcg_next(32'(r_x), MULT, ADD));

  // A reseed takes priority over a step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= BITS'(SEED);
    end else if (load_en) begin
      r_x <= load_val;
    end else if (step_en) begin
      r_x <= w_x_next;
    end
  end

  assign x = r_x;

endmodule
`default_nettype wire

// File: rtl/random_pos_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | random_pos_arbiter : round-robin shared LCG with rejection-sampled output |
// | Optional macro RANDOM_POS_FREE_RUN_EN: generator also steps while idle.   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module random_pos_arbiter
  import random_pos_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int BITS       = 11,
  parameter int SEED       = 3,
  parameter int MULT       = 5,
  parameter int ADD        = 3,
  parameter int RANGE_MIN  = 16,
  parameter int RANGE_SPAN = 600,
  parameter int MAX_TRIES  = 4,
  localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [BITS-1:0]  pos_out,
  output logic             pos_valid,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  input  logic             seed_load,
  input  logic [BITS-1:0]  seed_val
);

  localparam int              c_TW       = $clog2(MAX_TRIES + 1);
  localparam logic [BITS-1:0] c_MIN      = BITS'(RANGE_MIN);
  localparam logic [BITS-1:0] c_FALLBACK = BITS'(RANGE_MIN + RANGE_SPAN / 2);
  localparam logic [GW-1:0]   c_LAST     = GW'(N_REQ - 1);

  if ((N_REQ < 2) || (N_REQ > c_MAX_REQ)) begin : g_nreq_err
    $error("random_pos_arbiter: N_REQ must be 2..8");
  end
  if ((RANGE_SPAN < 1) || (RANGE_MIN + RANGE_SPAN > (1 << BITS))) begin : g_range_err
    $error("random_pos_arbiter: RANGE_MIN+RANGE_SPAN must fit in BITS");
  end
  if (MAX_TRIES < 1) begin : g_tries_err
    $error("random_pos_arbiter: MAX_TRIES must be at least 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_grant_id;
  logic [GW-1:0]     r_rr_ptr;
  logic [c_TW-1:0]   r_tries;
  logic [BITS-1:0]   r_pos_out;
  logic [BITS-1:0]   w_x;
  logic              w_step;
  logic              w_load;
  logic              w_grant;
  logic              w_in_range;
  logic              w_more;
  logic [GW-1:0]     w_pick;

  lcg_core #(
    .BITS (BITS),
    .SEED (SEED),
    .MULT (MULT),
    .ADD  (ADD)
  ) u_lcg (
    .clk      (clk),
    .reset_n  (reset_n),
    .step_en  (w_step),
    .load_en  (w_load),
    .load_val (seed_val),
    .x        (w_x)
  );

  assign w_in_range = int'(w_x) < RANGE_SPAN;
  assign w_more     = int'(r_tries) < MAX_TRIES;
  assign w_pick     = GW'(rr_pick(8'(req), 3'(r_rr_ptr), N_REQ));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_load      = 1'b0;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (seed_load) begin
          w_load = 1'b1;
        end else if (|req) begin
          w_grant     = 1'b1;
          w_state_nxt = STEP;
        end
`ifdef RANDOM_POS_FREE_RUN_EN
        else begin
          w_step = 1'b1;
        end
`endif
      end
      STEP: begin
        w_step      = 1'b1;
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if (w_in_range || !w_more) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = STEP;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_tries    <= '0;
      r_pos_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_grant_id <= w_pick;
            r_tries    <= '0;
          end
        end
        STEP: begin
          r_tries <= r_tries + c_TW'(1);
        end
        CHECK: begin
          // A rejected draw with tries left falls through and holds pos_out.
          if (w_in_range) begin
            r_pos_out <= c_MIN + w_x;
          end else if (!w_more) begin
            r_pos_out <= c_FALLBACK;
          end
        end
        DONE: begin
          r_rr_ptr <= (r_grant_id == c_LAST) ? '0 : r_grant_id + GW'(1);
        end
        default: begin
          r_tries <= '0;
        end
      endcase
    end
  end

  assign pos_valid = (r_state == DONE);
  assign ack       = (r_state == DONE) ? (N_REQ'(1) << r_grant_id) : '0;
  assign busy      = (r_state != IDLE);
  assign pos_out   = r_pos_out;
  assign grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_random_pos_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_random_pos_arbiter : scoreboard bench, default and MAX_TRIES=1 builds  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_random_pos_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_n0, rst_n1;
  logic [1:0]  req0, req1, ack0, ack1;
  logic [10:0] pos0, pos1, sv0, sv1;
  logic        pv0, pv1, gid0, gid1, busy0, busy1, sl0, sl1;

  random_pos_arbiter dut0 (
    .clk(clk), .reset_n(rst_n0), .req(req0), .ack(ack0), .pos_out(pos0),
    .pos_valid(pv0), .grant_id(gid0), .busy(busy0), .seed_load(sl0), .seed_val(sv0)
  );

  random_pos_arbiter #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .reset_n(rst_n1), .req(req1), .ack(ack1), .pos_out(pos1),
    .pos_valid(pv1), .grant_id(gid1), .busy(busy1), .seed_load(sl1), .seed_val(sv1)
  );

  typedef struct {
    int gid;
    int pos;
    int t;
    int lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int nserv0 = 0;
  int nserv1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push0(input int gid, input int pos, input int lat);
    exp_t e;
    e.gid = gid; e.pos = pos; e.t = cyc; e.lat = lat;
    q0.push_back(e);
  endtask

  task automatic push1(input int gid, input int pos, input int lat);
    exp_t e;
    e.gid = gid; e.pos = pos; e.t = cyc; e.lat = lat;
    q1.push_back(e);
  endtask

  task automatic wait_serv0(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (nserv0 >= target) break;
      @(posedge clk); #1;
    end
    if (nserv0 < target) begin
      checks++; errors++;
      $display("FAIL dut0 service timeout: got %0d services expected %0d", nserv0, target);
    end
  endtask

  task automatic wait_serv1(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (nserv1 >= target) break;
      @(posedge clk); #1;
    end
    if (nserv1 < target) begin
      checks++; errors++;
      $display("FAIL dut1 service timeout: got %0d services expected %0d", nserv1, target);
    end
  endtask

  always @(negedge clk) begin
    if (pv0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected pos_valid: got pos %0d expected none", pos0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 pos_out", int'(pos0), e.pos);
        chk("dut0 grant_id", int'(gid0), e.gid);
        chk("dut0 ack", int'(ack0), 1 << e.gid);
        if (e.lat != 0) chk("dut0 latency", cyc - e.t, e.lat);
      end
      nserv0++;
    end
  end

  always @(negedge clk) begin
    if (pv1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected pos_valid: got pos %0d expected none", pos1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 pos_out", int'(pos1), e.pos);
        chk("dut1 grant_id", int'(gid1), e.gid);
        chk("dut1 ack", int'(ack1), 1 << e.gid);
        if (e.lat != 0) chk("dut1 latency", cyc - e.t, e.lat);
      end
      nserv1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    req0 = '0; req1 = '0; sl0 = 1'b0; sl1 = 1'b0; sv0 = '0; sv1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ack", int'(ack0), 0);
    chk("reset pos_valid", int'(pv0), 0);
    chk("reset pos_out", int'(pos0), 0);
    chk("reset grant_id", int'(gid0), 0);
    chk("reset busy", int'(busy0), 0);
    @(negedge clk);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    @(posedge clk); #1;

    // req[0] held: four back-to-back services from the reset seed
    push0(0, 34, 3); push0(0, 109, 0); push0(0, 484, 0); push0(0, 311, 0);
    req0 = 2'b01;
    wait_serv0(nserv0 + 4, 60);
    req0 = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    chk("pos_out hold after 311", int'(pos0), 311);

    // two rejections before acceptance
    push0(0, 120, 7);
    req0 = 2'b01;
    wait_serv0(nserv0 + 1, 40);
    req0 = 2'b00;

    // seed_load while busy must not disturb x=104 -> 523
    push0(0, 539, 0);
    req0 = 2'b01;
    @(posedge clk); #1;
    sl0 = 1'b1; sv0 = '0;
    @(posedge clk); #1;
    sl0 = 1'b0;
    wait_serv0(nserv0 + 1, 40);
    req0 = 2'b00;

    // seed_load in IDLE
    sl0 = 1'b1; sv0 = '0;
    @(posedge clk); #1;
    sl0 = 1'b0;
    chk("busy after idle seed_load", int'(busy0), 0);
    push0(0, 19, 0);
    req0 = 2'b01;
    wait_serv0(nserv0 + 1, 40);
    req0 = 2'b00;

    // requester 1 alone moves rr_ptr back to 0
    push0(1, 34, 3);
    req0 = 2'b10;
    wait_serv0(nserv0 + 1, 40);
    req0 = 2'b00;

    // both held: alternating grants
    push0(0, 109, 0); push0(1, 484, 0); push0(0, 311, 0); push0(1, 120, 0);
    req0 = 2'b11;
    wait_serv0(nserv0 + 4, 80);
    req0 = 2'b00;
    @(posedge clk); #1;

    // reset during CHECK drops the in-flight request
    req0 = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy before mid-service reset", int'(busy0), 1);
    rst_n0 = 1'b0;
    #1;
    chk("mid reset ack", int'(ack0), 0);
    chk("mid reset pos_valid", int'(pv0), 0);
    chk("mid reset pos_out", int'(pos0), 0);
    chk("mid reset grant_id", int'(gid0), 0);
    chk("mid reset busy", int'(busy0), 0);
    push0(0, 34, 0);
    @(negedge clk);
    rst_n0 = 1'b1;
    @(posedge clk); #1;
    wait_serv0(nserv0 + 1, 40);
    req0 = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    chk("pos_out hold after 34", int'(pos0), 34);

    // MAX_TRIES=1: accept then fallback
    sl1 = 1'b1; sv1 = 11'd119;
    @(posedge clk); #1;
    sl1 = 1'b0;
    push1(0, 614, 3);
    req1 = 2'b01;
    wait_serv1(nserv1 + 1, 40);
    req1 = 2'b00;
    push1(0, 316, 3);
    req1 = 2'b01;
    wait_serv1(nserv1 + 1, 40);
    req1 = 2'b00;
    repeat (3) begin @(posedge clk); #1; end

    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
